h_assoc: RTL and testbench

//  Parametrised set-associative key/value hash table engine. Next generation of
//  the single-table h core: WAYS-way sets, in-place update, delete, occupancy

---
 rtl/h_assoc_pkg.sv | 32 +++
 rtl/h_assoc_if.sv | 33 +++
 rtl/h_assoc_set_cmp.sv | 35 +++
 rtl/h_assoc.sv | 177 +++++++++++++++++
 tb/tb_h_assoc.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/h_assoc_pkg.sv
// Shared types and default geometry for the set-associative hash engine.
// Encodings match the command/response port of the h top level.
package h_assoc_pkg;

  localparam int DEF_K_W  = 32;
  localparam int DEF_V_W  = 32;
  localparam int DEF_H_W  = 8;
  localparam int DEF_WAYS = 4;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_QUERY  = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_UPDATED = 3'd1,
    ST_HIT     = 3'd2,
    ST_MISS    = 3'd3,
    ST_FULL    = 3'd4
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HASH   = 2'd1,
    S_LOOKUP = 2'd2,
    S_SWEEP  = 2'd3
  } state_t;

endpackage

// File: rtl/h_assoc_if.sv
// Command/response, external-hash and occupancy bundle of the h_assoc engine.
// The slave side is the engine; the master side is the issuing client.
interface h_assoc_if import h_assoc_pkg::*; #(
  parameter int K_W  = DEF_K_W,
  parameter int V_W  = DEF_V_W,
  parameter int H_W  = DEF_H_W,
  parameter int WAYS = DEF_WAYS
);
  localparam int CNT_W = H_W + $clog2(WAYS) + 1;

  logic             i_cmd_vld_w;
  opcode_t          i_cmd_opcode_w;
  logic [K_W-1:0]   i_cmd_k_w;
  logic [V_W-1:0]   i_cmd_v_w;
  logic             o_cmd_rdy_w;
  logic             o_rsp_vld;
  status_t          o_rsp_status;
  logic [V_W-1:0]   o_rsp_v;
  logic [K_W-1:0]   o_hash_k_r;
  logic [H_W-1:0]   i_hash_h_w;
  logic [CNT_W-1:0] o_cnt;

  modport master (
    output i_cmd_vld_w, i_cmd_opcode_w, i_cmd_k_w, i_cmd_v_w, i_hash_h_w,
    input  o_cmd_rdy_w, o_rsp_vld, o_rsp_status, o_rsp_v, o_hash_k_r, o_cnt
  );

  modport slave (
    input  i_cmd_vld_w, i_cmd_opcode_w, i_cmd_k_w, i_cmd_v_w, i_hash_h_w,
    output o_cmd_rdy_w, o_rsp_vld, o_rsp_status, o_rsp_v, o_hash_k_r, o_cnt
  );

endinterface

// File: rtl/h_assoc_set_cmp.sv
// Combinational way matcher for one set: key hit detection and lowest-index
// free way selection.
module h_assoc_set_cmp #(
  parameter int K_W   = 32,
  parameter int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [K_W-1:0]             key,
  input  logic [WAYS-1:0]            valid,
  input  logic [WAYS-1:0][K_W-1:0]   keys,
  output logic                       hit,
  output logic [WAY_W-1:0]           hit_way,
  output logic                       free,
  output logic [WAY_W-1:0]           free_way
);

  // Scanning downward lets the lowest matching index win the last assignment.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i] == key)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_way = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/h_assoc.sv
// Set-associative key/value table engine: insert/update, delete, query and a
// one-set-per-cycle clear sweep, behind a 3-cycle accept/hash/lookup FSM.
module h_assoc import h_assoc_pkg::*; #(
  parameter int K_W  = DEF_K_W,
  parameter int V_W  = DEF_V_W,
  parameter int H_W  = DEF_H_W,
  parameter int WAYS = DEF_WAYS
) (
  input  logic     clk,
  input  logic     arst,
  h_assoc_if.slave bus
);

  localparam int SETS    = 2 ** H_W;
  localparam int WAY_W   = $clog2(WAYS);
  localparam int CNT_W   = H_W + WAY_W + 1;
  localparam int CNT_MAX = SETS * WAYS;

  state_t           state;
  opcode_t          op_p0;
  logic [K_W-1:0]   k_p0;
  logic [V_W-1:0]   v_p0;
  logic [H_W-1:0]   set_p1;
  logic [H_W-1:0]   sweep_idx;
  logic [CNT_W-1:0] cnt;
  logic             rsp_vld;
  status_t          rsp_status;
  logic [V_W-1:0]   rsp_v;

  logic [WAYS-1:0]            valid_mem [SETS];
  logic [WAYS-1:0][K_W-1:0]   k_mem     [SETS];
  logic [WAYS-1:0][V_W-1:0]   v_mem     [SETS];

  logic [WAYS-1:0]            rd_valid;
  logic [WAYS-1:0][K_W-1:0]   rd_k;
  logic [WAYS-1:0][V_W-1:0]   rd_v;
  logic                       hit, free;
  logic [WAY_W-1:0]           hit_way, free_way;
  logic                       in_lookup, ins_upd, ins_new, del_hit;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    if (inc && !dec) return c + CNT_W'(1);
    if (dec && !inc) return c - CNT_W'(1);
    return c;
  endfunction

  assign rd_valid = valid_mem[set_p1];
  assign rd_k     = k_mem[set_p1];
  assign rd_v     = v_mem[set_p1];

  h_assoc_set_cmp #(.K_W(K_W), .WAYS(WAYS)) u_set_cmp (
    .key      (k_p0),
    .valid    (rd_valid),
    .keys     (rd_k),
    .hit      (hit),
    .hit_way  (hit_way),
    .free     (free),
    .free_way (free_way)
  );

  assign in_lookup = (state == S_LOOKUP);
  assign ins_upd   = in_lookup && (op_p0 == OP_INSERT) && hit;
  assign ins_new   = in_lookup && (op_p0 == OP_INSERT) && !hit && free;
  assign del_hit   = in_lookup && (op_p0 == OP_DELETE) && hit;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= S_IDLE;
      op_p0      <= OP_CLEAR;
      k_p0       <= '0;
      set_p1     <= '0;
      sweep_idx  <= '0;
      cnt        <= '0;
      rsp_vld    <= 1'b0;
      rsp_status <= ST_OK;
      rsp_v      <= '0;
      for (int s = 0; s < SETS; s++) valid_mem[s] <= '0;
    end else begin
      rsp_vld <= 1'b0;
      case (state)
        // p0: accept, key goes straight out to the external hash
        S_IDLE: begin
          if (bus.i_cmd_vld_w) begin
            op_p0 <= bus.i_cmd_opcode_w;
            k_p0  <= bus.i_cmd_k_w;
            if (bus.i_cmd_opcode_w == OP_CLEAR) begin
              sweep_idx <= '0;
              state     <= S_SWEEP;
            end else begin
              state <= S_HASH;
            end
          end
        end
        // p1: hash index returns
        S_HASH: begin
          set_p1 <= bus.i_hash_h_w;
          state  <= S_LOOKUP;
        end
        // p2: single read-modify-write of the addressed set
        S_LOOKUP: begin
          state   <= S_IDLE;
          rsp_vld <= 1'b1;
          rsp_v   <= '0;
          cnt     <= cnt_step(cnt, ins_new, del_hit);
          case (op_p0)
            OP_INSERT: begin
              if (hit) begin
                rsp_status <= ST_UPDATED;
                rsp_v      <= rd_v[hit_way];
              end else if (free) begin
                rsp_status                  <= ST_OK;
                valid_mem[set_p1][free_way] <= 1'b1;
              end else begin
                rsp_status <= ST_FULL;
              end
            end
            OP_DELETE: begin
              if (hit) begin
                rsp_status                 <= ST_OK;
                rsp_v                      <= rd_v[hit_way];
                valid_mem[set_p1][hit_way] <= 1'b0;
              end else begin
                rsp_status <= ST_MISS;
              end
            end
            OP_QUERY: begin
              if (hit) begin
                rsp_status <= ST_HIT;
                rsp_v      <= rd_v[hit_way];
              end else begin
                rsp_status <= ST_MISS;
              end
            end
            default: rsp_status <= ST_OK;
          endcase
        end
        S_SWEEP: begin
          valid_mem[sweep_idx] <= '0;
          sweep_idx            <= sweep_idx + 1'b1;
          if (sweep_idx == H_W'(SETS - 1)) begin
            state      <= S_IDLE;
            rsp_vld    <= 1'b1;
            rsp_status <= ST_OK;
            rsp_v      <= '0;
            cnt        <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives in valid_mem.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && bus.i_cmd_vld_w) v_p0 <= bus.i_cmd_v_w;
    if (ins_new) begin
      k_mem[set_p1][free_way] <= k_p0;
      v_mem[set_p1][free_way] <= v_p0;
    end else if (ins_upd) begin
      v_mem[set_p1][hit_way] <= v_p0;
    end
  end

  assert property (@(posedge clk) disable iff (arst)
    !(ins_new && (cnt == CNT_W'(CNT_MAX))));
  assert property (@(posedge clk) disable iff (arst)
    !(del_hit && (cnt == '0)));

  assign bus.o_cmd_rdy_w  = (state == S_IDLE);
  assign bus.o_rsp_vld    = rsp_vld;
  assign bus.o_rsp_status = rsp_status;
  assign bus.o_rsp_v      = rsp_v;
  assign bus.o_hash_k_r   = k_p0;
  assign bus.o_cnt        = cnt;

endmodule

// File: tb/tb_h_assoc.sv
// Directed and scoreboard bench for h_assoc with the default 32/32/8/4 geometry.
module tb_h_assoc;
  import h_assoc_pkg::*;

  logic clk = 1'b0;
  logic arst;
  logic force_en;
  logic [7:0] force_val;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  h_assoc_if bus ();
  assign bus.i_hash_h_w = force_en ? force_val : bus.o_hash_k_r[7:0];

  h_assoc dut (.clk(clk), .arst(arst), .bus(bus));

  // Issues one command from a negedge and returns at the negedge showing the response.
  task automatic do_cmd(input opcode_t op, input logic [31:0] k, input logic [31:0] v,
                        input bit hold, output status_t st, output logic [31:0] rv,
                        output int lat);
    int n = 0;
    st = ST_OK; rv = '0; lat = -1;
    while (!bus.o_cmd_rdy_w && n < 2000) begin @(negedge clk); n++; end
    bus.i_cmd_vld_w = 1'b1; bus.i_cmd_opcode_w = op;
    bus.i_cmd_k_w = k; bus.i_cmd_v_w = v;
    @(posedge clk);
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (bus.o_rsp_vld) begin st = bus.o_rsp_status; rv = bus.o_rsp_v; lat = c; break; end
      if (hold) begin
        bus.i_cmd_vld_w = 1'b1; bus.i_cmd_opcode_w = OP_INSERT;
        bus.i_cmd_k_w = $urandom; bus.i_cmd_v_w = $urandom;
      end else bus.i_cmd_vld_w = 1'b0;
    end
    bus.i_cmd_vld_w = 1'b0;
  endtask

  task automatic test_reset();
    status_t st; logic [31:0] rv; int lat;
    checks++; if (bus.o_cmd_rdy_w !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%b exp=1", bus.o_cmd_rdy_w); end
    checks++; if (bus.o_rsp_vld !== 1'b0) begin failures++; $display("FAIL rst_rsp_vld got=%b exp=0", bus.o_rsp_vld); end
    checks++; if (bus.o_rsp_status !== ST_OK || bus.o_rsp_v !== 32'h0) begin failures++; $display("FAIL rst_rsp got=%0d/%h exp=0/0", bus.o_rsp_status, bus.o_rsp_v); end
    checks++; if (bus.o_hash_k_r !== 32'h0 || bus.o_cnt !== 11'd0) begin failures++; $display("FAIL rst_key_cnt got=%h/%0d exp=0/0", bus.o_hash_k_r, bus.o_cnt); end
    @(negedge clk); arst = 1'b0; @(negedge clk);
    do_cmd(OP_QUERY, 32'h10, 32'h0, 1'b0, st, rv, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL t1_latency got=%0d exp=3", lat); end
    checks++; if (st !== ST_MISS || rv !== 32'h0) begin failures++; $display("FAIL t1_query got=%0d/%h exp=%0d/0", st, rv, ST_MISS); end
    checks++; if (bus.o_cnt !== 11'd0) begin failures++; $display("FAIL t1_cnt got=%0d exp=0", bus.o_cnt); end
  endtask

  task automatic test_insert_update();
    status_t st; logic [31:0] rv; int lat;
    do_cmd(OP_INSERT, 32'h10, 32'hAA, 1'b0, st, rv, lat);
    checks++; if (st !== ST_OK || rv !== 32'h0 || lat !== 3) begin failures++; $display("FAIL t2_insert got=%0d/%h/%0d exp=0/0/3", st, rv, lat); end
    do_cmd(OP_QUERY, 32'h10, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_HIT || rv !== 32'hAA) begin failures++; $display("FAIL t2_query1 got=%0d/%h exp=%0d/aa", st, rv, ST_HIT); end
    do_cmd(OP_INSERT, 32'h10, 32'hBB, 1'b0, st, rv, lat);
    checks++; if (st !== ST_UPDATED || rv !== 32'hAA) begin failures++; $display("FAIL t2_update got=%0d/%h exp=%0d/aa", st, rv, ST_UPDATED); end
    do_cmd(OP_QUERY, 32'h10, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_HIT || rv !== 32'hBB) begin failures++; $display("FAIL t2_query2 got=%0d/%h exp=%0d/bb", st, rv, ST_HIT); end
    checks++; if (bus.o_cnt !== 11'd1) begin failures++; $display("FAIL t2_cnt got=%0d exp=1", bus.o_cnt); end
    @(negedge clk);
    checks++; if (bus.o_rsp_vld !== 1'b0 || bus.o_rsp_status !== ST_HIT || bus.o_rsp_v !== 32'hBB) begin failures++; $display("FAIL t2_rsp_pulse got=%b/%0d/%h exp=0/%0d/bb", bus.o_rsp_vld, bus.o_rsp_status, bus.o_rsp_v, ST_HIT); end
    do_cmd(OP_DELETE, 32'h10, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_OK || rv !== 32'hBB || bus.o_cnt !== 11'd0) begin failures++; $display("FAIL t2_delete got=%0d/%h/%0d exp=0/bb/0", st, rv, bus.o_cnt); end
  endtask

  task automatic test_full_set();
    status_t st; logic [31:0] rv; int lat;
    force_en = 1'b1; force_val = 8'd5;
    for (int k = 1; k <= 4; k++) begin
      do_cmd(OP_INSERT, 32'(k), 32'h100 + 32'(k), 1'b0, st, rv, lat);
      checks++; if (st !== ST_OK || rv !== 32'h0) begin failures++; $display("FAIL t3_insert_k%0d got=%0d/%h exp=0/0", k, st, rv); end
    end
    checks++; if (bus.o_cnt !== 11'd4) begin failures++; $display("FAIL t3_cnt got=%0d exp=4", bus.o_cnt); end
    do_cmd(OP_INSERT, 32'h6, 32'h106, 1'b0, st, rv, lat);
    checks++; if (st !== ST_FULL || rv !== 32'h0 || bus.o_cnt !== 11'd4) begin failures++; $display("FAIL t3_full got=%0d/%h/%0d exp=%0d/0/4", st, rv, bus.o_cnt, ST_FULL); end
    do_cmd(OP_QUERY, 32'h6, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_MISS) begin failures++; $display("FAIL t3_query6 got=%0d exp=%0d", st, ST_MISS); end
  endtask

  task automatic test_delete_reuse();
    status_t st; logic [31:0] rv; int lat;
    do_cmd(OP_DELETE, 32'h2, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_OK || rv !== 32'h102 || bus.o_cnt !== 11'd3) begin failures++; $display("FAIL t4_delete got=%0d/%h/%0d exp=0/102/3", st, rv, bus.o_cnt); end
    do_cmd(OP_INSERT, 32'h7, 32'h107, 1'b0, st, rv, lat);
    checks++; if (st !== ST_OK || bus.o_cnt !== 11'd4) begin failures++; $display("FAIL t4_insert7 got=%0d/%0d exp=0/4", st, bus.o_cnt); end
    do_cmd(OP_QUERY, 32'h7, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_HIT || rv !== 32'h107) begin failures++; $display("FAIL t4_query7 got=%0d/%h exp=%0d/107", st, rv, ST_HIT); end
    do_cmd(OP_QUERY, 32'h1, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_HIT || rv !== 32'h101) begin failures++; $display("FAIL t4_query1 got=%0d/%h exp=%0d/101", st, rv, ST_HIT); end
    do_cmd(OP_DELETE, 32'h2, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_MISS || rv !== 32'h0) begin failures++; $display("FAIL t4_delete_again got=%0d/%h exp=%0d/0", st, rv, ST_MISS); end
  endtask

  task automatic test_clear();
    status_t st; logic [31:0] rv; int lat; int rdy_hi; logic [10:0] cnt_at;
    logic [31:0] keys [4] = '{32'h1, 32'h3, 32'h4, 32'h7};
    st = ST_FULL; rv = 32'hDEAD; lat = -1; rdy_hi = 0; cnt_at = 11'h7FF;
    bus.i_cmd_vld_w = 1'b1; bus.i_cmd_opcode_w = OP_CLEAR; bus.i_cmd_k_w = 32'h0; bus.i_cmd_v_w = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      bus.i_cmd_vld_w = 1'b0;
      if (bus.o_rsp_vld) begin
        lat = c; st = bus.o_rsp_status; rv = bus.o_rsp_v; cnt_at = bus.o_cnt; break;
      end
      if (bus.o_cmd_rdy_w) rdy_hi++;
    end
    checks++; if (lat !== 257) begin failures++; $display("FAIL t5_latency got=%0d exp=257", lat); end
    checks++; if (rdy_hi !== 0) begin failures++; $display("FAIL t5_rdy_during_sweep got=%0d exp=0", rdy_hi); end
    checks++; if (st !== ST_OK || rv !== 32'h0 || cnt_at !== 11'd0) begin failures++; $display("FAIL t5_rsp got=%0d/%h/%0d exp=0/0/0", st, rv, cnt_at); end
    for (int i = 0; i < 4; i++) begin
      do_cmd(OP_QUERY, keys[i], 32'h0, 1'b0, st, rv, lat);
      checks++; if (st !== ST_MISS) begin failures++; $display("FAIL t5_query_k%0h got=%0d exp=%0d", keys[i], st, ST_MISS); end
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    status_t st; logic [31:0] rv; int lat; logic seen;
    do_cmd(OP_INSERT, 32'h20, 32'h55, 1'b0, st, rv, lat);
    checks++; if (st !== ST_OK || bus.o_cnt !== 11'd1) begin failures++; $display("FAIL t6_insert got=%0d/%0d exp=0/1", st, bus.o_cnt); end
    bus.i_cmd_vld_w = 1'b1; bus.i_cmd_opcode_w = OP_QUERY; bus.i_cmd_k_w = 32'h20;
    @(posedge clk);
    @(negedge clk); bus.i_cmd_vld_w = 1'b0;
    @(negedge clk); arst = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= bus.o_rsp_vld; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t6_no_rsp got=%b exp=0", seen); end
    checks++; if (bus.o_cmd_rdy_w !== 1'b1 || bus.o_cnt !== 11'd0 || bus.o_hash_k_r !== 32'h0) begin failures++; $display("FAIL t6_state got=%b/%0d/%h exp=1/0/0", bus.o_cmd_rdy_w, bus.o_cnt, bus.o_hash_k_r); end
    arst = 1'b0; @(negedge clk);
    do_cmd(OP_QUERY, 32'h20, 32'h0, 1'b0, st, rv, lat);
    checks++; if (st !== ST_MISS || rv !== 32'h0) begin failures++; $display("FAIL t6_query got=%0d/%h exp=%0d/0", st, rv, ST_MISS); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] map [logic [31:0]];
    logic [31:0] pool [7] = '{32'h05, 32'h105, 32'h205, 32'h305, 32'h405, 32'h06, 32'h106};
    for (int n = 0; n < 40; n++) begin
      opcode_t op; logic [31:0] k; logic [31:0] v; status_t est; logic [31:0] ev;
      status_t st; logic [31:0] rv; int lat; int same;
      k = pool[$urandom_range(0, 6)];
      v = $urandom;
      case ($urandom_range(1, 3))
        1: op = OP_INSERT;
        2: op = OP_DELETE;
        default: op = OP_QUERY;
      endcase
      ev = 32'h0;
      if (op == OP_INSERT) begin
        if (map.exists(k)) begin est = ST_UPDATED; ev = map[k]; map[k] = v; end
        else begin
          same = 0;
          foreach (map[kk]) if (kk[7:0] == k[7:0]) same++;
          if (same < 4) begin est = ST_OK; map[k] = v; end else est = ST_FULL;
        end
      end else if (op == OP_DELETE) begin
        if (map.exists(k)) begin est = ST_OK; ev = map[k]; map.delete(k); end
        else est = ST_MISS;
      end else begin
        if (map.exists(k)) begin est = ST_HIT; ev = map[k]; end else est = ST_MISS;
      end
      do_cmd(op, k, v, n[0], st, rv, lat);
      checks++; if (st !== est || rv !== ev || lat !== 3) begin failures++; $display("FAIL sb_op%0d op=%0d k=%h got=%0d/%h/%0d exp=%0d/%h/3", n, op, k, st, rv, lat, est, ev); end
      checks++; if (bus.o_cnt !== 11'(map.num())) begin failures++; $display("FAIL sb_cnt%0d got=%0d exp=%0d", n, bus.o_cnt, map.num()); end
    end
  endtask

  initial begin
    arst = 1'b1; force_en = 1'b0; force_val = 8'd0;
    bus.i_cmd_vld_w = 1'b0; bus.i_cmd_opcode_w = OP_QUERY;
    bus.i_cmd_k_w = '0; bus.i_cmd_v_w = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_insert_update();
    test_full_set();
    test_delete_reuse();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
